// File: rtl/scu_dsp_dma_bridge_pkg.sv
// Shared definitions for the SCU DSP DMA bridge: FSM states, B-bus window limits
// and the address classifier.
package SCUDSP_PKG;

  typedef enum logic [2:0] {IDLE, W32, H0, H1, FIN} DMABrState_t;

  localparam logic [24:0] SCU_BBUS_LO = 25'h1680000;
  localparam logic [24:0] SCU_BBUS_HI = 25'h17FFFFF;

  function automatic bit IsBBus(input logic [24:0] addr,
                                input logic [24:0] lo = SCU_BBUS_LO,
                                input logic [24:0] hi = SCU_BBUS_HI);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/scu_dsp_dma_bridge.sv
// Runs one-word DSP DMA requests on the SCU bus: a single 32-bit cycle, or a
// high/low pair of 16-bit cycles inside the B-bus window. Timeouts and overruns raise ERR.
module scu_dsp_dma_bridge
  import SCUDSP_PKG::*;
#(
  parameter logic [24:0] BB_LO  = SCU_BBUS_LO,
  parameter logic [24:0] BB_HI  = SCU_BBUS_HI,
  parameter logic [7:0]  TO_CYC = 8'd255
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE_R,
  input  logic [24:0] DSP_A,
  input  logic [31:0] DSP_DO,
  input  logic        DSP_WE,
  input  logic        DSP_REQ,
  output logic        DSP_ACK,
  output logic [31:0] DSP_DI,
  output logic [25:0] BUS_A,
  output logic [31:0] BUS_DO,
  input  logic [31:0] BUS_DI,
  output logic        BUS_WE,
  output logic        BUS_SZ,
  output logic        BUS_REQ,
  input  logic        BUS_RDY,
  output logic        BUSY,
  output logic        ERR,
  input  logic        ERR_CLR
);

  DMABrState_t state_reg;
  logic [24:0] a_reg;
  logic        we_reg;
  logic [31:0] do_reg;
  logic [31:0] rd_reg;
  logic [7:0]  to_cnt_reg;
  logic        bus_req_reg;
  logic [25:0] bus_a_reg;
  logic [31:0] bus_do_reg;
  logic        bus_we_reg;
  logic        bus_sz_reg;
  logic        dsp_ack_reg;
  logic [31:0] dsp_di_reg;
  logic        busy_reg;
  logic        err_reg;

  logic        in_bus;
  logic        overrun;
  logic        timeout;
  logic [31:0] rd_word;
  logic [31:0] bus_do_next;

  assign in_bus  = (state_reg == W32) || (state_reg == H0) || (state_reg == H1);
  assign overrun = DSP_REQ && (state_reg != IDLE);
  assign timeout = in_bus && bus_req_reg && !BUS_RDY && (to_cnt_reg <= 8'd1);

  // Read word as it will look once the current bus cycle's data is merged in.
  always_comb begin
    rd_word     = rd_reg;
    bus_do_next = do_reg;
    case (state_reg)
      W32: begin
        if (!we_reg) rd_word = BUS_DI;
      end
      H0: begin
        if (!we_reg) rd_word = {BUS_DI[15:0], rd_reg[15:0]};
        bus_do_next = {2{do_reg[31:16]}};
      end
      H1: begin
        if (!we_reg) rd_word = {rd_reg[31:16], BUS_DI[15:0]};
        bus_do_next = {2{do_reg[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg   <= IDLE;
      a_reg       <= '0;
      we_reg      <= 1'b0;
      do_reg      <= '0;
      rd_reg      <= '0;
      to_cnt_reg  <= '0;
      bus_req_reg <= 1'b0;
      bus_a_reg   <= '0;
      bus_do_reg  <= '0;
      bus_we_reg  <= 1'b0;
      bus_sz_reg  <= 1'b0;
      dsp_ack_reg <= 1'b0;
      dsp_di_reg  <= '0;
      busy_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else if (CE_R) begin
      dsp_ack_reg <= 1'b0;
      if (overrun || timeout) err_reg <= 1'b1;
      else if (ERR_CLR)       err_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (DSP_REQ) begin
            a_reg      <= DSP_A;
            we_reg     <= DSP_WE;
            do_reg     <= DSP_DO;
            rd_reg     <= '0;
            busy_reg   <= 1'b1;
            to_cnt_reg <= TO_CYC;
            state_reg  <= IsBBus(DSP_A, BB_LO, BB_HI) ? H0 : W32;
          end
        end
        W32, H0, H1: begin
          // First cycle of each bus state only sets up the bus; this gives the
          // one-cycle request latency and the one-cycle gap between halves.
          if (!bus_req_reg) begin
            bus_req_reg <= 1'b1;
            bus_a_reg   <= {a_reg, (state_reg == H1)};
            bus_sz_reg  <= (state_reg == W32);
            bus_we_reg  <= we_reg;
            bus_do_reg  <= bus_do_next;
          end else if (BUS_RDY) begin
            bus_req_reg <= 1'b0;
            rd_reg      <= rd_word;
            to_cnt_reg  <= TO_CYC;
            if (state_reg == H0) begin
              state_reg <= H1;
            end else begin
              state_reg   <= FIN;
              dsp_ack_reg <= 1'b1;
              dsp_di_reg  <= rd_word;
            end
          end else if (timeout) begin
            bus_req_reg <= 1'b0;
            rd_reg      <= '0;
            to_cnt_reg  <= TO_CYC;
            state_reg   <= FIN;
            dsp_ack_reg <= 1'b1;
            dsp_di_reg  <= '0;
          end else begin
            to_cnt_reg <= to_cnt_reg - 8'd1;
          end
        end
        FIN: begin
          busy_reg   <= 1'b0;
          to_cnt_reg <= TO_CYC;
          state_reg  <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign DSP_ACK = dsp_ack_reg;
  assign DSP_DI  = dsp_di_reg;
  assign BUS_A   = bus_a_reg;
  assign BUS_DO  = bus_do_reg;
  assign BUS_WE  = bus_we_reg;
  assign BUS_SZ  = bus_sz_reg;
  assign BUS_REQ = bus_req_reg;
  assign BUSY    = busy_reg;
  assign ERR     = err_reg;

endmodule

// File: tb/tb_scu_dsp_dma_bridge.sv
// Randomized bench for scu_dsp_dma_bridge: a bus responder with random wait states
// and a transaction-level model predicting bus cycles, ACK latency and read data.
module tb_scu_dsp_dma_bridge;

  localparam logic [7:0]  TO    = 8'd4;
  localparam logic [24:0] BB_LO = 25'h1680000;
  localparam logic [24:0] BB_HI = 25'h17FFFFF;

  logic        CLK = 1'b0;
  logic        RST_N, CE_R, DSP_WE, DSP_REQ, DSP_ACK;
  logic [24:0] DSP_A;
  logic [31:0] DSP_DO, DSP_DI, BUS_DO, BUS_DI;
  logic [25:0] BUS_A;
  logic        BUS_WE, BUS_SZ, BUS_REQ, BUS_RDY, BUSY, ERR, ERR_CLR;

  typedef struct packed {
    logic [25:0] a;
    logic        sz;
    logic        w;
    logic [31:0] d;
  } bcyc_t;

  int n_cmp = 0;
  int n_bad = 0;
  bit ce_jitter = 1'b0;
  int xfer_no = 0;

  scu_dsp_dma_bridge #(.BB_LO(BB_LO), .BB_HI(BB_HI), .TO_CYC(TO)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R),
    .DSP_A(DSP_A), .DSP_DO(DSP_DO), .DSP_WE(DSP_WE), .DSP_REQ(DSP_REQ),
    .DSP_ACK(DSP_ACK), .DSP_DI(DSP_DI),
    .BUS_A(BUS_A), .BUS_DO(BUS_DO), .BUS_DI(BUS_DI), .BUS_WE(BUS_WE),
    .BUS_SZ(BUS_SZ), .BUS_REQ(BUS_REQ), .BUS_RDY(BUS_RDY),
    .BUSY(BUSY), .ERR(ERR), .ERR_CLR(ERR_CLR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One enabled cycle, optionally preceded by idle CE_R=0 cycles.
  task automatic tick();
    if (ce_jitter) begin
      repeat ($urandom_range(0, 2)) begin
        CE_R = 1'b0;
        @(posedge CLK);
        #1;
      end
    end
    CE_R = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  function automatic bit in_bbus(input logic [24:0] a);
    return (a >= BB_LO) && (a <= BB_HI);
  endfunction

  // mode: 0 normal, 1 bus never ready, 2 overrun (+ERR_CLR same cycle), 3 reset during H1
  task automatic xfer(input logic [24:0] a, input logic we, input logic [31:0] dout,
                      input int d0, input int d1, input logic [31:0] di0,
                      input logic [31:0] di1, input int mode);
    bcyc_t       exp_q[$];
    bcyc_t       got_q[$];
    bcyc_t       cur;
    int          exp_ack, ack_k, acks, wait_c, nb, req_hi;
    bit          prev_req, unstable;
    logic [31:0] exp_di, got_di;

    ack_k = -1; acks = 0; wait_c = 0; nb = 0; req_hi = 0;
    prev_req = 1'b0; unstable = 1'b0; got_di = '0; cur = '0;

    if (!in_bbus(a)) begin
      exp_q.push_back('{a: {a, 1'b0}, sz: 1'b1, w: we, d: dout});
      exp_ack = (mode == 1) ? 2 + int'(TO) : 3 + d0;
      exp_di  = (mode == 1) ? 32'h0 : di0;
    end else begin
      exp_q.push_back('{a: {a, 1'b0}, sz: 1'b0, w: we, d: {2{dout[31:16]}}});
      exp_q.push_back('{a: {a, 1'b1}, sz: 1'b0, w: we, d: {2{dout[15:0]}}});
      exp_ack = 5 + d0 + d1;
      exp_di  = {di0[15:0], di1[15:0]};
    end

    chk("busy_before_req", BUSY, 1'b0);
    DSP_A = a; DSP_WE = we; DSP_DO = dout; DSP_REQ = 1'b1;
    tick();
    DSP_REQ = 1'b0;
    DSP_A = 25'($urandom); DSP_DO = $urandom; DSP_WE = ~we;

    for (int k = 1; k <= 40; k++) begin
      if (ack_k > 0 && k >= ack_k + 3) break;
      BUS_RDY = 1'b0;
      if (k == 1) chk("busy_in_flight", BUSY, 1'b1);
      if (mode == 2 && k == 1) begin
        DSP_REQ = 1'b1;
        ERR_CLR = 1'b1;
      end
      if (DSP_ACK) begin
        acks++;
        if (ack_k < 0) begin
          ack_k  = k;
          got_di = DSP_DI;
          chk("busy_at_ack", BUSY, 1'b1);
        end
      end
      if (BUS_REQ) begin
        req_hi++;
        if (!prev_req) begin
          cur = '{a: BUS_A, sz: BUS_SZ, w: BUS_WE, d: BUS_DO};
          got_q.push_back(cur);
          wait_c = 0;
        end else if (cur != {BUS_A, BUS_SZ, BUS_WE, BUS_DO}) begin
          unstable = 1'b1;
        end
        if (mode == 3 && nb == 1) begin
          RST_N = 1'b0;
          #1;
          chk("rst_bus_req", BUS_REQ, 1'b0);
          chk("rst_busy", BUSY, 1'b0);
          chk("rst_ack", DSP_ACK, 1'b0);
          repeat (2) @(posedge CLK);
          #1;
          RST_N = 1'b1;
          acks = 0;
          repeat (5) begin
            tick();
            if (DSP_ACK) acks++;
          end
          chk("rst_no_ack", acks, 0);
          chk("rst_idle_req", BUS_REQ, 1'b0);
          break;
        end
        if (mode != 1 && wait_c == ((nb == 0) ? d0 : d1)) begin
          BUS_RDY = 1'b1;
          BUS_DI  = (nb == 0) ? di0 : di1;
          nb++;
        end else begin
          wait_c++;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        // Stray ready with no request outstanding must be ignored.
        BUS_RDY = 1'b1;
        BUS_DI  = $urandom;
      end
      prev_req = BUS_REQ;
      tick();
      DSP_REQ = 1'b0;
      ERR_CLR = 1'b0;
    end
    BUS_RDY = 1'b0;

    if (mode != 3) begin
      chk("ack_latency", ack_k, exp_ack);
      chk("ack_count", acks, 1);
      chk("bus_cycles", got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        chk("bus_a", got_q[i].a, exp_q[i].a);
        chk("bus_sz", got_q[i].sz, exp_q[i].sz);
        chk("bus_we", got_q[i].w, exp_q[i].w);
        if (we) chk("bus_do", got_q[i].d, exp_q[i].d);
      end
      chk("bus_stable", unstable, 1'b0);
      if (!we) chk("dsp_di", got_di, exp_di);
      chk("busy_after", BUSY, 1'b0);
      if (mode == 1) chk("timeout_req_cycles", req_hi, int'(TO));
      chk("err_flag", ERR, (mode == 1 || mode == 2) ? 1'b1 : 1'b0);
    end
    xfer_no++;
    $display("xfer %0d A=%h WE=%0d mode=%0d ack@%0d exp@%0d di=%h", xfer_no, a, we, mode,
             ack_k, exp_ack, got_di);
  endtask

  task automatic clear_err();
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
    chk("err_cleared", ERR, 1'b0);
  endtask

  initial begin
    logic [24:0] ra;
    RST_N = 1'b0; CE_R = 1'b1; DSP_A = '0; DSP_DO = '0; DSP_WE = 1'b0; DSP_REQ = 1'b0;
    BUS_DI = '0; BUS_RDY = 1'b0; ERR_CLR = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_ack", DSP_ACK, 1'b0);
    chk("reset_busy", BUSY, 1'b0);
    chk("reset_err", ERR, 1'b0);
    chk("reset_bus_req", BUS_REQ, 1'b0);
    chk("reset_bus_a", BUS_A, 26'h0);
    chk("reset_dsp_di", DSP_DI, 32'h0);
    RST_N = 1'b1;
    tick();

    xfer(25'h0180000, 1'b0, 32'h0, 2, 0, 32'hDEADBEEF, 32'h0, 0);
    xfer(25'h1680010, 1'b1, 32'h12345678, 0, 0, 32'h0, 32'h0, 0);
    xfer(25'h1680010, 1'b0, 32'h0, 0, 0, 32'h1111CAFE, 32'h2222F00D, 0);
    xfer(25'h0000100, 1'b0, 32'h0, 0, 0, 32'h0, 32'h0, 1);
    xfer(25'h0180004, 1'b0, 32'h0, 1, 0, 32'hA5A55A5A, 32'h0, 2);
    clear_err();
    xfer(25'h1700000, 1'b0, 32'h0, 1, 0, 32'h00001234, 32'h00005678, 3);
    xfer(25'h0180008, 1'b0, 32'h0, 0, 0, 32'h0BADF00D, 32'h0, 0);

    // Window edges.
    xfer(BB_LO - 25'd1, 1'b1, 32'h89ABCDEF, 3, 0, 32'h0, 32'h0, 0);
    xfer(BB_LO, 1'b0, 32'h0, 3, 3, 32'h0000ABCD, 32'h0000EF01, 0);
    xfer(BB_HI, 1'b1, 32'hFEDCBA98, 1, 2, 32'h0, 32'h0, 0);
    xfer(BB_HI + 25'd1, 1'b0, 32'h0, 0, 0, 32'h13579BDF, 32'h0, 0);

    for (int i = 0; i < 60; i++) begin
      ce_jitter = (i >= 30);
      if ($urandom_range(0, 1) == 1) ra = BB_LO + 25'($urandom_range(0, 32'h17FFFF));
      else ra = 25'($urandom);
      xfer(ra, 1'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom, $urandom, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
